// File: rtl/light_pkg.sv
// Shared encodings for the dimmer: brightness levels, per-level duty targets
// and button bit positions.
package light_pkg;

  typedef enum logic [2:0] {
    LVL_0 = 3'd0,
    LVL_1 = 3'd1,
    LVL_2 = 3'd2,
    LVL_3 = 3'd3,
    LVL_4 = 3'd4
  } level_t;

  localparam logic [7:0] DUTY_L0 = 8'd0;
  localparam logic [7:0] DUTY_L1 = 8'd64;
  localparam logic [7:0] DUTY_L2 = 8'd128;
  localparam logic [7:0] DUTY_L3 = 8'd192;
  localparam logic [7:0] DUTY_L4 = 8'd255;

  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_OFF = 2;

  function automatic logic [7:0] level_duty(input level_t lvl);
    case (lvl)
      LVL_1:   return DUTY_L1;
      LVL_2:   return DUTY_L2;
      LVL_3:   return DUTY_L3;
      LVL_4:   return DUTY_L4;
      default: return DUTY_L0;
    endcase
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One push-button: 2-flop synchronizer, debounce counter and a single-cycle
// pulse on each accepted press (releases produce nothing).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          differs;
  logic          flip;

  assign differs = (sync_p1 != stable_q);
  assign flip    = differs && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  // High in the cycle before the debounced state rises, so the consumer acts
  // on the same edge that accepts the press.
  assign o_press = flip && sync_p1;

  // stage p0/p1: metastability guard
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= i_raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce: accept a new level only after it has persisted long enough
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flip) begin
      stable_q <= sync_p1;
      cnt_q    <= '0;
    end else if (differs) begin
      cnt_q    <= cnt_q + CW'(1);
    end else begin
      cnt_q    <= '0;
    end
  end

endmodule

// File: rtl/light_dimmer_ctrl.sv
// PWM light controller: conditioned up/down/off buttons drive a 5-level
// brightness FSM, the duty fades toward the level target, PWM drives the LED.
module light_dimmer_ctrl
  import light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 200000,
  parameter int CLK_DIV          = 16,
  parameter int FADE_STEP_CYCLES = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_button,
  output logic [2:0] o_level,
  output logic [7:0] o_duty,
  output logic       o_busy,
  output logic       o_pwm
);

  localparam int FW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]    press;
  level_t        level_q;
  level_t        level_d;
  logic [7:0]    target_q;
  logic [7:0]    target_d;
  logic [FW-1:0] fade_cnt;
  logic          fade_wrap;
  logic [7:0]    duty_d;
  logic [PW-1:0] pre_cnt;
  logic          pwm_tick;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_latch;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_raw  (i_button[i]),
      .o_press(press[i])
    );
  end

  // level FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) level_q <= LVL_0;
    else         level_q <= level_d;
  end

  // level FSM: next state, off beats down beats up
  always_comb begin
    level_d = level_q;
    if (press[BTN_OFF]) begin
      level_d = LVL_0;
    end else if (press[BTN_DN]) begin
      case (level_q)
        LVL_4:   level_d = LVL_3;
        LVL_3:   level_d = LVL_2;
        LVL_2:   level_d = LVL_1;
        default: level_d = LVL_0;
      endcase
    end else if (press[BTN_UP]) begin
      case (level_q)
        LVL_0:   level_d = LVL_1;
        LVL_1:   level_d = LVL_2;
        LVL_2:   level_d = LVL_3;
        default: level_d = LVL_4;
      endcase
    end
  end

  // level FSM: outputs
  always_comb begin
    o_level  = level_q;
    target_q = level_duty(level_q);
    target_d = level_duty(level_d);
  end

  // fade: one LSB toward the current target per step period; off is immediate
  assign fade_wrap = (fade_cnt == FW'(FADE_STEP_CYCLES - 1));

  always_comb begin
    duty_d = o_duty;
    if (press[BTN_OFF]) begin
      duty_d = 8'd0;
    end else if (fade_wrap) begin
      if (o_duty < target_q)      duty_d = o_duty + 8'd1;
      else if (o_duty > target_q) duty_d = o_duty - 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fade_cnt <= '0;
      o_duty   <= 8'd0;
      o_busy   <= 1'b0;
    end else begin
      fade_cnt <= (press[BTN_OFF] || fade_wrap) ? '0 : fade_cnt + FW'(1);
      o_duty   <= duty_d;
      o_busy   <= (duty_d != target_d);
    end
  end

  // pwm: duty is latched only at the period boundary so a period never glitches
  assign pwm_tick = (pre_cnt == PW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_cnt    <= '0;
      pwm_cnt    <= 8'd0;
      duty_latch <= 8'd0;
      o_pwm      <= 1'b0;
    end else begin
      pre_cnt <= pwm_tick ? '0 : pre_cnt + PW'(1);
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) duty_latch <= o_duty;
      end
      o_pwm <= (duty_latch == 8'hFF) || (pwm_cnt < duty_latch);
    end
  end

endmodule

// File: doc/light_dimmer_ctrl.md
Name: light_dimmer_ctrl

Overview:
Top-level controller for the PWM light. It conditions three raw buttons (up/down/off) and sequences a 5-level brightness state. It fades the duty cycle toward the level's target and drives the LED through a glitch-free PWM output. It sits between the board push-buttons and the LED pin.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive stable clocks required to accept a button change (min 2)
CLK_DIV, 16, i_clk cycles per PWM counter tick (min 1; 1 = tick every clock)
FADE_STEP_CYCLES, 4096, i_clk cycles per 1-LSB duty step while fading (min 1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_button  in  3  raw async buttons, active-high: [0]=up, [1]=down, [2]=off
o_level  out  3  current brightness level, 0..4
o_duty  out  8  current faded duty value, 0..255
o_busy  out  1  high while o_duty != target duty of o_level
o_pwm  out  1  PWM drive to LED

Behaviour:
- Reset is asynchronous and active-high on i_reset; clock is i_clk. Reset values: o_level=0, o_duty=0, o_busy=0, o_pwm=0, all counters=0, debounced states=0.
- Button conditioning, per bit:
  - 2-flop synchronizer.
  - Debounce counter. It increments while the synced input differs from the debounced state and clears when they match. When the count reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - Press pulse: 1 cycle high on the debounced 0->1 edge. No event on release.
  - Held button gives exactly one pulse (no auto-repeat).
- Level FSM, states L0..L4. Transitions occur on the clock edge after a pulse.
  - up: Ln -> Ln+1. Saturates at L4.
  - down: Ln -> Ln-1. Saturates at L0.
  - off: any -> L0.
  - Simultaneous pulses, priority off > down > up. Only one transition per cycle.
- Target duty per level: L0=0, L1=64, L2=128, L3=192, L4=255.
- Fade:
  - Fade-step counter runs freely modulo FADE_STEP_CYCLES.
  - On its wrap, o_duty moves 1 LSB toward target. No overshoot.
  - Exception: an off pulse forces o_duty=0 on the same edge that sets L0, and clears the fade counter.
  - Target changes mid-fade take effect at the next step; no restart, direction reverses if needed.
  - o_busy = (o_duty != target), registered alongside o_duty.
- PWM:
  - Prescaler divides i_clk by CLK_DIV to a tick. 8-bit counter pwm_cnt increments on each tick, wrapping 255->0.
  - Duty latch: captures o_duty when pwm_cnt wraps to 0. Latch is 0 after reset.
  - o_pwm is registered: 1 if latch==255, else (pwm_cnt < latch).
  - Duty 0 gives constant low; duty 255 gives constant high.
  - Duty changes never take effect mid-period.
- Reset mid-fade or mid-debounce: everything returns to reset values immediately. o_pwm goes low asynchronously.

Decomposition:
- Package light_pkg:
  - level encodings LVL_0..LVL_4 (3-bit).
  - duty table constants DUTY_L0..DUTY_L4.
  - button index constants BTN_UP=0, BTN_DN=1, BTN_OFF=2.
- Sub-module button_conditioner (synchronizer + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated 3 times.
- Level FSM, fade and PWM stay in light_dimmer_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CLK_DIV=1, FADE_STEP_CYCLES=2.
1. Reset, then hold up high 20 cycles -> o_level 0->1 exactly once, about 6 cycles after assertion (2 sync + 4 debounce). o_duty ramps 1 LSB per 2 cycles to 64, o_busy drops when o_duty==64.
2. Up glitch of 2 cycles, then low -> no pulse, o_level stays 0. Press up 5 times total -> o_level=4 with target 255. Press down at L0 -> stays 0.
3. Reach L4 with o_duty=255, press off -> o_level=0 and o_duty=0 on the same edge, o_busy=0. o_pwm goes low from the next PWM period.
4. Hold up and off together from L2 -> single transition to L0. Hold down+up from L3 -> L2.
5. At L2 with o_duty=128 -> o_pwm is high exactly 128 of 256 cycles per period. Change level mid-period -> high-time changes only after pwm_cnt wraps to 0.
6. Assert i_reset asynchronously mid-fade (o_duty=40 ramping) -> all outputs 0 before the next clock edge. After release the bench restarts cleanly, reproducing scenario 1.
